udp_loopback_buf: RTL

Parametrised UDP payload store-and-forward buffer on the user side of `eth`. It queues whole received UDP frames in a byte RAM with a frame-length FIFO, drops frames that cannot be stored complete, and replays each queued frame through the `eth` UDP transmit handshake. Optionally the payload is inverted. It generalises the fixed echo path of the top level into a multi-frame, depth-configurable loopback engine.

---
 rtl/udp_loopback_buf_pkg.sv | 29 ++
 rtl/udp_loopback_buf_if.sv | 28 ++
 rtl/udp_loopback_buf_len_fifo.sv | 56 +++++
 rtl/udp_loopback_buf.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/udp_loopback_buf_pkg.sv
// Shared types and defaults for the UDP loopback buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package udp_loopback_buf_pkg;

  localparam int UDP_LEN_W = 16;

  localparam int MODE_ECHO = 0;
  localparam int MODE_INV  = 1;

  localparam int DEF_DATA_DEPTH = 2048;
  localparam int DEF_LEN_DEPTH  = 8;
  localparam int DEF_MAX_LEN    = 1472;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LOAD,
    TX_ARM,
    TX_WAIT_BUSY,
    TX_SEND,
    TX_WAIT_IDLE
  } tx_state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [UDP_LEN_W-1:0] sat_inc(input logic [UDP_LEN_W-1:0] v);
    return (v == {UDP_LEN_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/udp_loopback_buf_if.sv
// UDP user-side bus between eth and the loopback buffer (rx payload + tx handshake).
// Latency: n/a (wires only).
// Backpressure: tx side is paced by tx_rdy/udp_tx_req; rx side has none.
interface udp_loopback_buf_if;
  import udp_loopback_buf_pkg::*;

  logic                 udp_rx_data_vld;
  logic [7:0]           udp_rx_data;
  logic                 udp_rx_done;
  logic                 tx_rdy;
  logic                 udp_tx_req;
  logic                 udp_tx_en;
  logic [UDP_LEN_W-1:0] udp_tx_data_num;
  logic [7:0]           udp_tx_data;

  // eth side: produces received payload and pulls transmit bytes
  modport master (
    output udp_rx_data_vld, udp_rx_data, udp_rx_done, tx_rdy, udp_tx_req,
    input  udp_tx_en, udp_tx_data_num, udp_tx_data
  );

  // buffer side
  modport slave (
    input  udp_rx_data_vld, udp_rx_data, udp_rx_done, tx_rdy, udp_tx_req,
    output udp_tx_en, udp_tx_data_num, udp_tx_data
  );

endinterface

// File: rtl/udp_loopback_buf_len_fifo.sv
// Synchronous frame-length FIFO with full/empty flags and occupancy count.
// Latency: pushed entry visible at the head one cycle after push; head is show-ahead.
// Backpressure: push ignored when full, pop ignored when empty.
module udp_len_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/udp_loopback_buf.sv
// Store-and-forward UDP payload loopback: queues whole rx frames, replays them via eth tx.
// Latency: byte stored 1 cycle after vld; commit visible 1 cycle after done; tx byte 1 cycle after req.
// Backpressure: frames that do not fit (space, MAX_LEN or length slots) are dropped and counted.
module udp_loopback_buf
  import udp_loopback_buf_pkg::*;
#(
  parameter int DATA_DEPTH = DEF_DATA_DEPTH,
  parameter int LEN_DEPTH  = DEF_LEN_DEPTH,
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int MODE       = MODE_ECHO
) (
  input  logic                         gmii_rx_clk,
  input  logic                         rst_n,
  udp_loopback_buf_if.slave            bus,
  output logic [$clog2(LEN_DEPTH):0]   frames_queued,
  output logic [UDP_LEN_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [7:0] INV_MASK = (MODE == MODE_INV) ? 8'hFF : 8'h00;

  logic [7:0] mem [DATA_DEPTH];

  // Receive side state. wr_ptr is the committed end, wr_tmp the in-progress end.
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        wr_tmp;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        used;
  logic [UDP_LEN_W-1:0] rx_cnt;
  logic                 drop;

  logic                 rx_acc;
  logic                 rx_ovf;
  logic [UDP_LEN_W-1:0] rx_cnt_nxt;
  logic [PW-1:0]        wr_tmp_nxt;
  logic                 drop_nxt;
  logic                 commit;

  // Transmit side state.
  tx_state_t            state;
  logic [UDP_LEN_W-1:0] tx_len;
  logic [UDP_LEN_W-1:0] tx_cnt;
  logic                 rd_en;

  // Length FIFO connections.
  logic                 fifo_pop;
  logic [UDP_LEN_W-1:0] fifo_dat;
  logic                 fifo_full;
  logic                 fifo_empty;

  assign used = wr_tmp - rd_ptr;

  // A same-cycle byte is folded in before the done decision, so these
  // "next" values are what the commit logic looks at.
  assign rx_acc     = bus.udp_rx_data_vld && !drop
                    && (used < PW'(DATA_DEPTH))
                    && (rx_cnt < UDP_LEN_W'(MAX_LEN));
  assign rx_ovf     = bus.udp_rx_data_vld && !drop && !rx_acc;
  assign rx_cnt_nxt = rx_cnt + {{(UDP_LEN_W-1){1'b0}}, rx_acc};
  assign wr_tmp_nxt = wr_tmp + {{(PW-1){1'b0}}, rx_acc};
  assign drop_nxt   = drop || rx_ovf;
  assign commit     = bus.udp_rx_done && !drop_nxt && (rx_cnt_nxt != '0) && !fifo_full;

  assign rd_en    = ((state == TX_WAIT_BUSY) || (state == TX_SEND))
                  && bus.udp_tx_req && (tx_cnt < tx_len);
  assign fifo_pop = (state == TX_LOAD);

  udp_len_fifo #(
    .W     (UDP_LEN_W),
    .DEPTH (LEN_DEPTH)
  ) u_len_fifo (
    .clk      (gmii_rx_clk),
    .rst_n    (rst_n),
    .push     (commit),
    .push_dat (rx_cnt_nxt),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (frames_queued)
  );

  // Payload RAM write port; address wraps naturally on the low pointer bits.
  always_ff @(posedge gmii_rx_clk) begin
    if (rx_acc) mem[wr_tmp[AW-1:0]] <= bus.udp_rx_data;
  end

  // Receive bookkeeping: accept bytes, then commit or roll back on done.
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      wr_tmp   <= '0;
      rx_cnt   <= '0;
      drop     <= 1'b0;
      drop_cnt <= '0;
    end else if (bus.udp_rx_done) begin
      rx_cnt <= '0;
      drop   <= 1'b0;
      if (commit) begin
        wr_ptr <= wr_tmp_nxt;
        wr_tmp <= wr_tmp_nxt;
      end else begin
        wr_tmp   <= wr_ptr;
        drop_cnt <= sat_inc(drop_cnt);
      end
    end else begin
      rx_cnt <= rx_cnt_nxt;
      wr_tmp <= wr_tmp_nxt;
      drop   <= drop_nxt;
    end
  end

  // Transmit FSM with registered outputs; the RAM read register doubles as udp_tx_data.
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= TX_IDLE;
      tx_len              <= '0;
      tx_cnt              <= '0;
      rd_ptr              <= '0;
      bus.udp_tx_en       <= 1'b0;
      bus.udp_tx_data_num <= '0;
      bus.udp_tx_data     <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (!fifo_empty && bus.tx_rdy) state <= TX_LOAD;
        end
        TX_LOAD: begin
          tx_len              <= fifo_dat;
          bus.udp_tx_data_num <= fifo_dat;
          tx_cnt              <= '0;
          bus.udp_tx_en       <= 1'b1;
          state               <= TX_ARM;
        end
        TX_ARM: begin
          bus.udp_tx_en <= 1'b0;
          state         <= TX_WAIT_BUSY;
        end
        TX_WAIT_BUSY: begin
          if (!bus.tx_rdy) state <= TX_SEND;
        end
        TX_SEND: begin
          if (tx_cnt == tx_len) state <= TX_WAIT_IDLE;
        end
        TX_WAIT_IDLE: begin
          if (bus.tx_rdy) state <= TX_IDLE;
        end
        default: state <= TX_IDLE;
      endcase

      if (rd_en) begin
        bus.udp_tx_data <= mem[rd_ptr[AW-1:0]] ^ INV_MASK;
        rd_ptr          <= rd_ptr + 1'b1;
        tx_cnt          <= tx_cnt + 1'b1;
      end
    end
  end

endmodule
